hms_clock_core: RTL and testbench

//   Single-clock HH:MM:SS timekeeper with setup mode, successor to the min/sec clock.
//   All counters run on clk with one-cycle enables; no derived clocks. Debounce and edge detect are built in.

---
 rtl/hms_clock_core.sv | 215 +++++++++++++++++++++
 tb/tb_hms_clock_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hms_clock_core.sv
// rtl/hms_clock_core.sv - HH:MM:SS timekeeper with debounced setup buttons
// Purpose:
//   Single-clock hours/minutes/seconds counter with a 1 Hz tick, a setup mode
//   with a 3-position field cursor, and a 2 Hz blink phase for the selected field.
//   All timing is derived from clk through one-cycle enables.
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   i_sw0 / i_sw1 / i_sw2   mode / position / increment buttons (active-low, async)
//   o_sec, o_min, o_hour    time fields (hour 0..23, or 1..12 with o_pm)
//   o_pm                    PM flag in 12h builds, constant 0 in 24h builds
//   o_mode                  0 = CLOCK, 1 = SETUP
//   o_position              selected field: 0 = SEC, 1 = MIN, 2 = HOUR
//   o_tick_1hz              one-cycle pulse per second in CLOCK mode
//   o_blink                 blink phase of the selected field, 0 in CLOCK mode
module hms_clock_core #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEB_DIV      = 500_000,
    parameter int HOUR_MODE_24 = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_pm,
    output logic       o_mode,
    output logic [1:0] o_position,
    output logic       o_tick_1hz,
    output logic       o_blink
);

    localparam int TICK_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DEB_W     = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam int BLINK_DIV = (CLK_HZ / 4 >= 1) ? CLK_HZ / 4 : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(CLK_HZ - 1);
    localparam logic [TICK_W-1:0]  TICK_ONE  = TICK_W'(1);
    localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_ONE   = DEB_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);

    localparam bit         IS_24H   = (HOUR_MODE_24 != 0);
    localparam logic [4:0] HOUR_RST = IS_24H ? 5'd0 : 5'd12;

    typedef enum logic {
        MODE_CLOCK = 1'b0,
        MODE_SETUP = 1'b1
    } mode_t;

    // ------------------------------------------------------------------
    // Button path: synchroniser, sampled debounce, press-edge detect.
    // Bit order everywhere: [0] mode, [1] position, [2] increment.
    // ------------------------------------------------------------------
    logic [2:0]       w_sw_raw;
    logic [2:0]       r_sw_meta;
    logic [2:0]       r_sw_sync;
    logic [2:0]       r_samp_cur;
    logic [2:0]       r_samp_prev;
    logic [2:0]       r_pressed_d;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [2:0]       w_pressed;
    logic [2:0]       w_evt;

    assign w_sw_raw = {i_sw2, i_sw1, i_sw0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta   <= 3'b111;
            r_sw_sync   <= 3'b111;
            r_samp_cur  <= 3'b111;
            r_samp_prev <= 3'b111;
            r_pressed_d <= 3'b000;
            r_deb_cnt   <= '0;
        end else begin
            r_sw_meta <= w_sw_raw;
            r_sw_sync <= r_sw_meta;
            if (r_deb_cnt == DEB_MAX) begin
                r_deb_cnt   <= '0;
                r_samp_prev <= r_samp_cur;
                r_samp_cur  <= r_sw_sync;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_ONE;
            end
            r_pressed_d <= w_pressed;
        end
    end

    // Pressed only when two consecutive samples are low; a single low sample
    // is treated as bounce. The event fires once on the rising edge of pressed.
    assign w_pressed = ~r_samp_cur & ~r_samp_prev;
    assign w_evt     = w_pressed & ~r_pressed_d;

    // Mode beats everything; position beats increment.
    logic w_mode_evt;
    logic w_pos_evt;
    logic w_inc_evt;

    assign w_mode_evt = w_evt[0];
    assign w_pos_evt  = w_evt[1] & ~w_evt[0];
    assign w_inc_evt  = w_evt[2] & ~w_evt[1] & ~w_evt[0];

    // ------------------------------------------------------------------
    // Time fields and mode state
    // ------------------------------------------------------------------
    mode_t              r_mode;
    logic [1:0]         r_position;
    logic [5:0]         r_sec;
    logic [5:0]         r_min;
    logic [4:0]         r_hour;
    logic               r_pm;
    logic               r_tick;
    logic               r_blink;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;

    logic [5:0] w_sec_inc;
    logic [5:0] w_min_inc;
    logic [4:0] w_hour_inc;
    logic       w_tick_wrap;

    assign w_sec_inc   = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
    assign w_min_inc   = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
    assign w_tick_wrap = (r_tick_cnt == TICK_MAX);

    always_comb begin
        w_hour_inc = r_hour + 5'd1;
        if (IS_24H) begin
            if (r_hour == 5'd23) begin
                w_hour_inc = 5'd0;
            end
        end else if (r_hour == 5'd12) begin
            w_hour_inc = 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_CLOCK;
            r_position  <= 2'd0;
            r_sec       <= 6'd0;
            r_min       <= 6'd0;
            r_hour      <= HOUR_RST;
            r_pm        <= 1'b0;
            r_tick      <= 1'b0;
            r_blink     <= 1'b0;
            r_tick_cnt  <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_tick <= 1'b0;
            if (w_mode_evt) begin
                // Both directions restart the second, so CLOCK resumes with a full second.
                r_tick_cnt  <= '0;
                r_blink_cnt <= '0;
                if (r_mode == MODE_CLOCK) begin
                    r_mode     <= MODE_SETUP;
                    r_position <= 2'd0;
                    r_blink    <= 1'b1;
                end else begin
                    r_mode  <= MODE_CLOCK;
                    r_blink <= 1'b0;
                end
            end else if (r_mode == MODE_CLOCK) begin
                if (w_tick_wrap) begin
                    r_tick_cnt <= '0;
                    r_tick     <= 1'b1;
                    r_sec      <= w_sec_inc;
                    // Full carry chain resolves in this one cycle.
                    if (r_sec == 6'd59) begin
                        r_min <= w_min_inc;
                        if (r_min == 6'd59) begin
                            r_hour <= w_hour_inc;
                            if (!IS_24H && r_hour == 5'd11) begin
                                r_pm <= ~r_pm;
                            end
                        end
                    end
                end else begin
                    r_tick_cnt <= r_tick_cnt + TICK_ONE;
                end
            end else begin
                if (r_blink_cnt == BLINK_MAX) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BLINK_ONE;
                end
                if (w_pos_evt) begin
                    r_position <= (r_position == 2'd2) ? 2'd0 : r_position + 2'd1;
                end else if (w_inc_evt) begin
                    // Setup increments wrap the single field, no carry, PM untouched.
                    case (r_position)
                        2'd0:    r_sec  <= w_sec_inc;
                        2'd1:    r_min  <= w_min_inc;
                        default: r_hour <= w_hour_inc;
                    endcase
                end
            end
        end
    end

    assign o_sec      = r_sec;
    assign o_min      = r_min;
    assign o_hour     = r_hour;
    assign o_pm       = r_pm;
    assign o_mode     = (r_mode == MODE_SETUP);
    assign o_position = r_position;
    assign o_tick_1hz = r_tick;
    assign o_blink    = r_blink;

endmodule

// File: tb/tb_hms_clock_core.sv
// tb/tb_hms_clock_core.sv - directed table-driven bench for hms_clock_core
module tb_hms_clock_core;

    localparam int CLK_HZ  = 20;
    localparam int DEB_DIV = 2;
    localparam int HOLD    = 4 * DEB_DIV + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sw24;   // {inc, pos, mode}, active-low
    logic [2:0] sw12;

    logic [5:0] s24_sec, s24_min, s12_sec, s12_min;
    logic [4:0] s24_hour, s12_hour;
    logic       s24_pm, s24_mode, s24_tick, s24_blink;
    logic       s12_pm, s12_mode, s12_tick, s12_blink;
    logic [1:0] s24_pos, s12_pos;

    always #5 clk = ~clk;

    hms_clock_core #(.CLK_HZ(CLK_HZ), .DEB_DIV(DEB_DIV), .HOUR_MODE_24(1)) dut24 (
        .clk(clk), .rst_n(rst_n),
        .i_sw0(sw24[0]), .i_sw1(sw24[1]), .i_sw2(sw24[2]),
        .o_sec(s24_sec), .o_min(s24_min), .o_hour(s24_hour), .o_pm(s24_pm),
        .o_mode(s24_mode), .o_position(s24_pos), .o_tick_1hz(s24_tick), .o_blink(s24_blink)
    );

    hms_clock_core #(.CLK_HZ(CLK_HZ), .DEB_DIV(DEB_DIV), .HOUR_MODE_24(0)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .i_sw0(sw12[0]), .i_sw1(sw12[1]), .i_sw2(sw12[2]),
        .o_sec(s12_sec), .o_min(s12_min), .o_hour(s12_hour), .o_pm(s12_pm),
        .o_mode(s12_mode), .o_position(s12_pos), .o_tick_1hz(s12_tick), .o_blink(s12_blink)
    );

    int cur = 0;   // 0 = 24h instance, 1 = 12h instance
    int n_run = 0;
    int n_fail = 0;

    int obs_sec, obs_min, obs_hour, obs_pm, obs_mode, obs_pos, obs_tick;
    assign obs_sec  = (cur == 1) ? int'(s12_sec)  : int'(s24_sec);
    assign obs_min  = (cur == 1) ? int'(s12_min)  : int'(s24_min);
    assign obs_hour = (cur == 1) ? int'(s12_hour) : int'(s24_hour);
    assign obs_pm   = (cur == 1) ? int'(s12_pm)   : int'(s24_pm);
    assign obs_mode = (cur == 1) ? int'(s12_mode) : int'(s24_mode);
    assign obs_pos  = (cur == 1) ? int'(s12_pos)  : int'(s24_pos);
    assign obs_tick = (cur == 1) ? int'(s12_tick) : int'(s24_tick);

    typedef struct {
        int sel;
        int op;     // 0 mode, 1 position, 2 increment
        int n;
        int sec;
        int min;
        int hour;
        int pm;
        int mode;
        int pos;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int sel, input int op, input int n, input int sec,
                           input int min, input int hour, input int pm, input int mode,
                           input int pos);
        vec_t v;
        v.sel = sel; v.op = op; v.n = n; v.sec = sec; v.min = min;
        v.hour = hour; v.pm = pm; v.mode = mode; v.pos = pos;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input int sel, input int op, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 1) sw12[op] = 1'b0;
            else          sw24[op] = 1'b0;
            repeat (HOLD) @(negedge clk);
            sw12 = 3'b111;
            sw24 = 3'b111;
            repeat (HOLD) @(negedge clk);
        end
    endtask

    task automatic wait_mode(input int target, output int ok);
        ok = 0;
        for (int i = 0; i < 60 && ok == 0; i++) begin
            @(negedge clk);
            if (obs_mode == target) ok = 1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Hold the buttons in mask until CLOCK mode appears, then expect the
    // fields to stay put for 19 cycles and roll over on the 20th.
    task automatic roll_check(input string tag, input logic [2:0] mask,
                              input int s0, input int m0, input int h0, input int p0,
                              input int s1, input int m1, input int h1, input int p1);
        int ok;
        if (cur == 1) sw12 = ~mask;
        else          sw24 = ~mask;
        wait_mode(0, ok);
        chk({tag, " enter CLOCK"}, ok, 1);
        if (ok == 1) begin
            repeat (19) @(negedge clk);
            chk({tag, " sec@19"},  obs_sec,  s0);
            chk({tag, " min@19"},  obs_min,  m0);
            chk({tag, " hour@19"}, obs_hour, h0);
            chk({tag, " pm@19"},   obs_pm,   p0);
            chk({tag, " tick@19"}, obs_tick, 0);
            @(negedge clk);
            chk({tag, " sec@20"},  obs_sec,  s1);
            chk({tag, " min@20"},  obs_min,  m1);
            chk({tag, " hour@20"}, obs_hour, h1);
            chk({tag, " pm@20"},   obs_pm,   p1);
            chk({tag, " tick@20"}, obs_tick, 1);
        end
        sw12 = 3'b111;
        sw24 = 3'b111;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cur = vecs[i].sel;
            press(vecs[i].sel, vecs[i].op, vecs[i].n);
            chk($sformatf("vec%0d sec", i),  obs_sec,  vecs[i].sec);
            chk($sformatf("vec%0d min", i),  obs_min,  vecs[i].min);
            chk($sformatf("vec%0d hour", i), obs_hour, vecs[i].hour);
            chk($sformatf("vec%0d pm", i),   obs_pm,   vecs[i].pm);
            chk($sformatf("vec%0d mode", i), obs_mode, vecs[i].mode);
            chk($sformatf("vec%0d pos", i),  obs_pos,  vecs[i].pos);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_tick, n_ticks, bad_ticks, toggles, setup_ticks, ok;
        logic prev_blink;

        // 24h setup rows: start at 00:00:00, SETUP, position SEC.
        add_vec(0, 2,  3,  3,  0,  0, 0, 1, 0);
        add_vec(0, 1,  2,  3,  0,  0, 0, 1, 2);
        add_vec(0, 2,  5,  3,  0,  5, 0, 1, 2);
        add_vec(0, 2, 18,  3,  0, 23, 0, 1, 2);
        add_vec(0, 2,  1,  3,  0,  0, 0, 1, 2);
        add_vec(0, 2,  7,  3,  0,  7, 0, 1, 2);
        add_vec(0, 1,  1,  3,  0,  7, 0, 1, 0);
        add_vec(0, 1,  1,  3,  0,  7, 0, 1, 1);
        add_vec(0, 2, 59,  3, 59,  7, 0, 1, 1);
        add_vec(0, 2,  1,  3,  0,  7, 0, 1, 1);
        add_vec(0, 2, 59,  3, 59,  7, 0, 1, 1);
        add_vec(0, 1,  1,  3, 59,  7, 0, 1, 2);
        add_vec(0, 2, 16,  3, 59, 23, 0, 1, 2);
        add_vec(0, 1,  1,  3, 59, 23, 0, 1, 0);
        add_vec(0, 2, 55, 58, 59, 23, 0, 1, 0);
        // 12h rows: start at 12:00:00 AM in CLOCK.
        add_vec(1, 0,  1,  0,  0, 12, 0, 1, 0);
        add_vec(1, 1,  2,  0,  0, 12, 0, 1, 2);
        add_vec(1, 2,  1,  0,  0,  1, 0, 1, 2);
        add_vec(1, 2, 10,  0,  0, 11, 0, 1, 2);
        add_vec(1, 1,  1,  0,  0, 11, 0, 1, 0);
        add_vec(1, 2, 59, 59,  0, 11, 0, 1, 0);
        add_vec(1, 1,  1, 59,  0, 11, 0, 1, 1);
        add_vec(1, 2, 59, 59, 59, 11, 0, 1, 1);

        // Reset held while buttons chatter.
        rst_n = 1'b0;
        sw24  = 3'b111;
        sw12  = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sw24 = 3'(i);
            sw12 = 3'(7 - i);
        end
        chk("rst sec",      int'(s24_sec),   0);
        chk("rst min",      int'(s24_min),   0);
        chk("rst hour24",   int'(s24_hour),  0);
        chk("rst mode",     int'(s24_mode),  0);
        chk("rst pos",      int'(s24_pos),   0);
        chk("rst tick",     int'(s24_tick),  0);
        chk("rst blink",    int'(s24_blink), 0);
        chk("rst hour12",   int'(s12_hour),  12);
        chk("rst pm12",     int'(s12_pm),    0);
        sw24 = 3'b111;
        sw12 = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;

        // Free run for 60 seconds.
        first_tick = -1;
        n_ticks    = 0;
        bad_ticks  = 0;
        for (int e = 1; e <= 1200; e++) begin
            @(negedge clk);
            if (s24_tick) begin
                n_ticks++;
                if (first_tick < 0) first_tick = e;
                if (e % 20 != 0) bad_ticks++;
            end
            if (e == 1199) begin
                chk("run sec@1199", int'(s24_sec), 59);
                chk("run min@1199", int'(s24_min), 0);
            end
        end
        chk("first tick cycle", first_tick, 20);
        chk("tick count", n_ticks, 60);
        chk("misplaced ticks", bad_ticks, 0);
        chk("run sec@1200", int'(s24_sec), 0);
        chk("run min@1200", int'(s24_min), 1);
        chk("run hour@1200", int'(s24_hour), 0);
        chk("12h hour@1200", int'(s12_hour), 12);

        // Enter SETUP on the 24h instance.
        pulse_reset();
        cur = 0;
        sw24[0] = 1'b0;
        wait_mode(1, ok);
        chk("enter SETUP", ok, 1);
        chk("setup blink", int'(s24_blink), 1);
        chk("setup pos", int'(s24_pos), 0);
        chk("setup sec", int'(s24_sec), 0);
        sw24 = 3'b111;
        repeat (HOLD) @(negedge clk);

        run_rows(0, 14);

        // Blink every 5 cycles, no tick while in SETUP.
        toggles     = 0;
        setup_ticks = 0;
        prev_blink  = s24_blink;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s24_blink != prev_blink) toggles++;
            if (s24_tick) setup_ticks++;
            prev_blink = s24_blink;
        end
        chk("blink toggles/40", toggles, 8);
        chk("setup ticks", setup_ticks, 0);

        // One-sample glitch on increment is ignored.
        sw24[2] = 1'b0;
        repeat (DEB_DIV) @(negedge clk);
        sw24[2] = 1'b1;
        repeat (HOLD) @(negedge clk);
        chk("glitch sec", int'(s24_sec), 58);

        // Three sample periods low gives exactly one increment.
        sw24[2] = 1'b0;
        repeat (3 * DEB_DIV) @(negedge clk);
        sw24[2] = 1'b1;
        repeat (HOLD) @(negedge clk);
        chk("3-sample press sec", int'(s24_sec), 59);

        // Mode+inc together: mode wins, sec stays 59, then full rollover.
        roll_check("24h", 3'b101, 59, 59, 23, 0, 0, 0, 0, 0);

        // Reset in the middle of SETUP.
        press(0, 0, 1);
        press(0, 1, 2);
        press(0, 2, 5);
        chk("pre-reset hour", int'(s24_hour), 5);
        chk("pre-reset mode", int'(s24_mode), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst mode",   int'(s24_mode),  0);
        chk("async rst pos",    int'(s24_pos),   0);
        chk("async rst sec",    int'(s24_sec),   0);
        chk("async rst min",    int'(s24_min),   0);
        chk("async rst hour",   int'(s24_hour),  0);
        chk("async rst blink",  int'(s24_blink), 0);
        chk("async rst hour12", int'(s12_hour),  12);
        chk("async rst min12",  int'(s12_min),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // 12h instance: set 11:59:59 AM, expect 12:00:00 PM.
        run_rows(15, 22);
        cur = 1;
        roll_check("12h", 3'b001, 59, 59, 11, 0, 0, 0, 12, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
